// File: rtl/reg_sched_pkg.sv
// ============================================================================
//  Module      : reg_sched_pkg
//  Description : Shared types for the display register write scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_sched_pkg;

    localparam int c_REG_ADDR_W = 3;
    localparam int c_REG_DATA_W = 8;

    typedef logic [c_REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [c_REG_DATA_W-1:0] reg_data_t;

    // Register command space, shared with the SPI command receiver
    typedef enum logic [c_REG_ADDR_W-1:0] {
        SPRITE_DATA = 3'd0,
        COLOR1      = 3'd1,
        COLOR2      = 3'd2,
        COLOR3      = 3'd3,
        COLOR4      = 3'd4,
        SPRITE_X    = 3'd5,
        SPRITE_Y    = 3'd6,
        MISC        = 3'd7
    } reg_cmd_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

endpackage : reg_sched_pkg

`default_nettype wire

// File: rtl/reg_update_scheduler_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter; grants the first valid
//                requester at or after ptr, wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    int   w_winner;
    logic w_found;

    // Descending scan so the smallest distance from ptr is written last
    always_comb begin
        w_winner = 0;
        w_found  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            for (int i = 0; i < N; i++) begin
                if (valid[i] && (i == ((int'(ptr) + k) % N))) begin
                    w_winner = i;
                    w_found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (enable && w_found) begin
            for (int i = 0; i < N; i++) begin
                grant[i] = (i == w_winner);
            end
            grant_idx = IDX_W'(w_winner);
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/reg_update_scheduler.sv
// ============================================================================
//  Module      : reg_update_scheduler
//  Description : Arbitrates register writes from several requesters into an
//                in-order FIFO and drains it inside the vertical-blank window.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_update_scheduler
    import reg_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    input  logic                        vblank_i,
    input  logic                        defer_i,
    output logic                        reg_we_o,
    output logic [ADDR_W-1:0]           reg_addr_o,
    output logic [DATA_W-1:0]           reg_wdata_o,
    output logic [$clog2(DEPTH):0]      pending_o,
    output logic                        busy_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_ST_EMPTY = ST_EMPTY;
    localparam logic [1:0] c_ST_HOLD  = ST_HOLD;
    localparam logic [1:0] c_ST_DRAIN = ST_DRAIN;

    logic [c_PTR_W:0]    r_wr_ptr;
    logic [c_PTR_W:0]    r_rd_ptr;
    logic [c_PTR_W:0]    r_count;
    logic [1:0]          r_state;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0]   r_mem_addr [DEPTH];
    logic [DATA_W-1:0]   r_mem_data [DEPTH];

    logic                w_full;
    logic                w_empty;
    logic                w_drain_en;
    logic                w_push;
    logic                w_pop;
    logic [NUM_REQ-1:0]  w_grant;
    logic [c_IDX_W-1:0]  w_grant_idx;
    logic [ADDR_W-1:0]   w_push_addr;
    logic [DATA_W-1:0]   w_push_data;
    logic [c_PTR_W:0]    w_count_nxt;
    logic [1:0]          w_state_nxt;

    // Wrap bit differs with equal index bits only when the FIFO is full
    assign w_full     = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                        (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_drain_en = !defer_i || vblank_i;
    assign w_pop      = !w_empty && w_drain_en;
    assign w_push     = |(req_valid_i & w_grant);

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .valid     (req_valid_i),
        .ptr       (r_rr_ptr),
        .enable    (!w_full),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign req_ready_o = w_grant & {NUM_REQ{!rst_i}};

    always_comb begin
        w_push_addr = '0;
        w_push_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_push_addr = req_addr_i[i*ADDR_W +: ADDR_W];
                w_push_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = c_ST_EMPTY;
        if (w_count_nxt != '0) begin
            w_state_nxt = w_drain_en ? c_ST_DRAIN : c_ST_HOLD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr[c_PTR_W-1:0]] <= w_push_addr;
            r_mem_data[r_wr_ptr[c_PTR_W-1:0]] <= w_push_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= c_ST_EMPTY;
            r_rr_ptr    <= '0;
            reg_we_o    <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_state  <= w_state_nxt;
            reg_we_o <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= (w_grant_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                reg_addr_o  <= r_mem_addr[r_rd_ptr[c_PTR_W-1:0]];
                reg_wdata_o <= r_mem_data[r_rd_ptr[c_PTR_W-1:0]];
            end
        end
    end

    assign pending_o = r_count;
    assign busy_o    = (r_state != c_ST_EMPTY);

endmodule : reg_update_scheduler

`default_nettype wire

// File: tb/tb_reg_update_scheduler.sv
// ============================================================================
//  Module      : tb_reg_update_scheduler
//  Description : Scoreboard bench for reg_update_scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_update_scheduler;

    localparam int NUM_REQ = 2;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;

    logic                        clk_i = 1'b0;
    logic                        rst_i;
    logic [NUM_REQ-1:0]          req_valid_i;
    logic [NUM_REQ-1:0]          req_ready_o;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr_i;
    logic [NUM_REQ*DATA_W-1:0]   req_data_i;
    logic                        vblank_i;
    logic                        defer_i;
    logic                        reg_we_o;
    logic [ADDR_W-1:0]           reg_addr_o;
    logic [DATA_W-1:0]           reg_wdata_o;
    logic [$clog2(DEPTH):0]      pending_o;
    logic                        busy_o;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t sb[$];
    int  grants[$];
    wr_t r_exp;
    int  errors   = 0;
    int  checks   = 0;
    int  n_strobe = 0;
    int  n_accept = 0;
    int  s0;
    int  a0;

    reg_update_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .vblank_i    (vblank_i),
        .defer_i     (defer_i),
        .reg_we_o    (reg_we_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .pending_o   (pending_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_valid_i[i]                 = v;
        req_addr_i[i*ADDR_W +: ADDR_W] = a;
        req_data_i[i*DATA_W +: DATA_W] = d;
    endtask

    // Strobes are checked against the scoreboard; handshakes feed it
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (reg_we_o) begin
                n_strobe++;
                check("strobe_has_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    r_exp = sb.pop_front();
                    check("wr_addr", 32'(reg_addr_o), 32'(r_exp.a));
                    check("wr_data", 32'(reg_wdata_o), 32'(r_exp.d));
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid_i[i] && req_ready_o[i]) begin
                    sb.push_back({req_addr_i[i*ADDR_W +: ADDR_W], req_data_i[i*DATA_W +: DATA_W]});
                    grants.push_back(i);
                    n_accept++;
                end
            end
        end
    end

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_data_i  = '0;
        vblank_i    = 1'b0;
        defer_i     = 1'b0;
        step(2);
        req_valid_i = 2'b11;
        #1;
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_we", 32'(reg_we_o), 32'd0);
        check("rst_addr", 32'(reg_addr_o), 32'd0);
        check("rst_wdata", 32'(reg_wdata_o), 32'd0);
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        req_valid_i = '0;
        rst_i       = 1'b0;
        step(1);

        // Immediate mode
        set_req(0, 1'b1, 3'd5, 8'h3C);
        step(1);
        set_req(0, 1'b0, 3'd0, 8'h00);
        check("imm_we_e0", 32'(reg_we_o), 32'd0);
        check("imm_pending_e0", 32'(pending_o), 32'd1);
        step(1);
        check("imm_we_e1", 32'(reg_we_o), 32'd1);
        check("imm_addr", 32'(reg_addr_o), 32'd5);
        check("imm_data", 32'(reg_wdata_o), 32'h3C);
        check("imm_pending_e1", 32'(pending_o), 32'd0);
        step(1);
        check("imm_we_e2", 32'(reg_we_o), 32'd0);
        check("imm_busy_e2", 32'(busy_o), 32'd0);

        // Deferred hold, same-address writes kept in order
        defer_i = 1'b1;
        s0 = n_strobe;
        set_req(0, 1'b1, 3'd2, 8'h11); step(1);
        set_req(0, 1'b1, 3'd2, 8'h22); step(1);
        set_req(0, 1'b1, 3'd7, 8'h33); step(1);
        set_req(0, 1'b0, 3'd0, 8'h00); step(2);
        check("hold_pending", 32'(pending_o), 32'd3);
        check("hold_busy", 32'(busy_o), 32'd1);
        check("hold_no_strobe", 32'(n_strobe - s0), 32'd0);
        vblank_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("hold_drain_we", 32'(reg_we_o), 32'd1);
        end
        step(1);
        vblank_i = 1'b0;
        check("hold_drain_done_we", 32'(reg_we_o), 32'd0);
        check("hold_drain_strobes", 32'(n_strobe - s0), 32'd3);
        check("hold_drain_busy", 32'(busy_o), 32'd0);

        // Round robin with FIFO draining; a req1 write first parks rr_ptr at 0
        defer_i = 1'b0;
        set_req(1, 1'b1, 3'd6, 8'h55); step(1);
        set_req(1, 1'b0, 3'd0, 8'h00); step(3);
        grants.delete();
        s0 = n_strobe;
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1'b1, 3'd1, 8'(8'h40 + k));
            set_req(1, 1'b1, 3'd6, 8'(8'h80 + k));
            #1;
            check("rr_ready_onehot", 32'($countones(req_ready_o)), 32'd1);
            step(1);
        end
        req_valid_i = '0;
        step(3);
        check("rr_grant_count", 32'(grants.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < grants.size()) check("rr_grant_seq", 32'(grants[k]), 32'(k % 2));
        end
        check("rr_strobes", 32'(n_strobe - s0), 32'd6);
        check("rr_pending", 32'(pending_o), 32'd0);

        // Full backpressure
        defer_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 3'(k + 1), 8'(8'hC0 + k));
            step(1);
        end
        set_req(0, 1'b1, 3'd3, 8'hA0);
        set_req(1, 1'b1, 3'd4, 8'hB0);
        #1;
        check("full_ready", 32'(req_ready_o), 32'd0);
        check("full_pending", 32'(pending_o), 32'd4);
        step(1);
        check("full_ready_held", 32'(req_ready_o), 32'd0);
        a0 = n_accept;
        s0 = n_strobe;
        vblank_i = 1'b1;
        #1;
        check("full_ready_vblank", 32'(req_ready_o), 32'd0);
        step(1);
        vblank_i = 1'b0;
        #1;
        check("full_ready_after_pop", 32'(req_ready_o), 32'b10);
        step(1);
        check("full_ready_refull", 32'(req_ready_o), 32'd0);
        step(2);
        req_valid_i = '0;
        check("full_accepts", 32'(n_accept - a0), 32'd1);
        check("full_strobes", 32'(n_strobe - s0), 32'd1);
        check("full_pending_end", 32'(pending_o), 32'd4);

        // Window closes mid-drain
        s0 = n_strobe;
        vblank_i = 1'b1;
        step(2);
        vblank_i = 1'b0;
        step(3);
        check("close_strobes", 32'(n_strobe - s0), 32'd2);
        check("close_pending", 32'(pending_o), 32'd2);
        check("close_busy", 32'(busy_o), 32'd1);
        check("close_we", 32'(reg_we_o), 32'd0);

        // Asynchronous reset mid-drain
        set_req(0, 1'b1, 3'd0, 8'hD1); step(1);
        set_req(0, 1'b1, 3'd7, 8'hD2); step(1);
        set_req(0, 1'b0, 3'd0, 8'h00);
        vblank_i = 1'b1;
        step(1);
        check("arst_pre_we", 32'(reg_we_o), 32'd1);
        check("arst_pre_pending", 32'(pending_o), 32'd3);
        req_valid_i = 2'b11;
        #2;
        rst_i = 1'b1;
        #1;
        sb.delete();
        check("arst_we", 32'(reg_we_o), 32'd0);
        check("arst_addr", 32'(reg_addr_o), 32'd0);
        check("arst_wdata", 32'(reg_wdata_o), 32'd0);
        check("arst_pending", 32'(pending_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_ready", 32'(req_ready_o), 32'd0);
        req_valid_i = '0;
        step(2);
        rst_i   = 1'b0;
        defer_i = 1'b0;
        s0 = n_strobe;
        step(4);
        check("arst_no_strobe", 32'(n_strobe - s0), 32'd0);
        check("arst_pending_after", 32'(pending_o), 32'd0);

        // Address 0 forwarded after recovery
        set_req(0, 1'b1, 3'd0, 8'hFF);
        step(1);
        set_req(0, 1'b0, 3'd0, 8'h00);
        step(1);
        check("addr0_we", 32'(reg_we_o), 32'd1);
        check("addr0_addr", 32'(reg_addr_o), 32'd0);
        check("addr0_data", 32'(reg_wdata_o), 32'hFF);
        step(2);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_update_scheduler

`default_nettype wire
